// File: rtl/lcd_bus_monitor.sv
// Passive HD44780 bus monitor: decodes LCD writes into a 2x16 DDRAM shadow and
// display-control state, with a registered character read port. Never drives the bus.
module lcd_bus_monitor #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_e,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [7:0] lcd_data,
  input  logic [4:0] rd_idx,
  output logic [7:0] rd_char,
  output logic       disp_on,
  output logic       inc_mode,
  output logic       init_done,
  output logic       busy,
  output logic       cmd_strobe,
  output logic       drop_err,
  output logic [6:0] ddram_addr
);

  typedef struct packed {
    logic       e;
    logic       rs;
    logic       rw;
    logic [7:0] data;
  } bus_t;

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam logic [7:0] BLANK = 8'h20;

  bus_t       sync_q [SYNC_STAGES];
  bus_t       hist_q;
  state_t     state;
  logic [4:0] clr_cnt;
  logic [7:0] cells [32];
  logic       fs38;

  // The whole bus moves through one chain so RS/RW/DATA stay aligned with E.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      hist_q <= '0;
    end else begin
      sync_q[0] <= '{e: lcd_e, rs: lcd_rs, rw: lcd_rw, data: lcd_data};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  logic       fall, wr, line1, line2;
  logic [4:0] wr_idx;

  assign fall   = hist_q.e & ~sync_q[SYNC_STAGES-1].e;
  assign wr     = fall & ~hist_q.rw;
  assign line1  = (ddram_addr[6:4] == 3'b000);
  assign line2  = (ddram_addr[6:4] == 3'b100);
  assign wr_idx = {line2, ddram_addr[3:0]};

  function automatic logic [6:0] step(input logic [6:0] a, input logic inc);
    if (inc) begin
      if (a == 7'h27)      step = 7'h40;
      else if (a == 7'h67) step = 7'h00;
      else                 step = a + 7'd1;
    end else begin
      if (a == 7'h00)      step = 7'h67;
      else if (a == 7'h40) step = 7'h27;
      else                 step = a - 7'd1;
    end
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      clr_cnt    <= '0;
      for (int i = 0; i < 32; i++) cells[i] <= BLANK;
      ddram_addr <= '0;
      inc_mode   <= 1'b1;
      disp_on    <= 1'b0;
      init_done  <= 1'b0;
      fs38       <= 1'b0;
      busy       <= 1'b0;
      cmd_strobe <= 1'b0;
      drop_err   <= 1'b0;
      rd_char    <= BLANK;
    end else begin
      cmd_strobe <= 1'b0;
      rd_char    <= cells[rd_idx];
      case (state)
        IDLE: begin
          if (wr && hist_q.rs) begin
            cmd_strobe <= 1'b1;
            if (line1 || line2) cells[wr_idx] <= hist_q.data;
            ddram_addr <= step(ddram_addr, inc_mode);
          end else if (wr && hist_q.data != 8'h00) begin
            cmd_strobe <= 1'b1;
            casez (hist_q.data)
              8'b1???????: ddram_addr <= hist_q.data[6:0];
              8'b01??????: ;
              8'b001?????: fs38 <= (hist_q.data == 8'h38);
              8'b0001????: ;
              8'b00001???: begin
                disp_on <= hist_q.data[2];
                if (hist_q.data[2] && fs38) init_done <= 1'b1;
              end
              8'b000001??: inc_mode   <= hist_q.data[1];
              8'b0000001?: ddram_addr <= '0;
              default: begin
                state      <= CLEAR;
                busy       <= 1'b1;
                clr_cnt    <= '0;
                ddram_addr <= '0;
                inc_mode   <= 1'b1;
              end
            endcase
          end
        end
        CLEAR: begin
          cells[clr_cnt] <= BLANK;
          clr_cnt        <= clr_cnt + 5'd1;
          if (clr_cnt == 5'd31) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          if (wr) drop_err <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_bus_monitor.sv
// Directed bench for lcd_bus_monitor: drives HD44780 bus cycles and checks the shadow.
module tb_lcd_bus_monitor;
  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lcd_e = 1'b0, lcd_rs = 1'b0, lcd_rw = 1'b0;
  logic [7:0] lcd_data = 8'h00;
  logic [4:0] rd_idx = 5'd0;
  logic [7:0] rd_char;
  logic       disp_on, inc_mode, init_done, busy, cmd_strobe, drop_err;
  logic [6:0] ddram_addr;

  int n_cmp = 0, n_bad = 0;
  int strobe_cnt = 0, busy_cnt = 0;

  lcd_bus_monitor #(.SYNC_STAGES(S)) dut (
    .clk(clk), .rst(rst), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_data(lcd_data), .rd_idx(rd_idx), .rd_char(rd_char), .disp_on(disp_on),
    .inc_mode(inc_mode), .init_done(init_done), .busy(busy), .cmd_strobe(cmd_strobe),
    .drop_err(drop_err), .ddram_addr(ddram_addr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cmd_strobe) strobe_cnt++;
    if (busy) busy_cnt++;
  end

  task automatic bus_cycle(input logic rs, input logic rw, input logic [7:0] d);
    @(negedge clk);
    lcd_rs = rs; lcd_rw = rw; lcd_data = d; lcd_e = 1'b1;
    repeat (S + 3) @(negedge clk);
    lcd_e = 1'b0;
    repeat (S + 4) @(negedge clk);
  endtask

  task automatic cmd(input logic [7:0] d);
    bus_cycle(1'b0, 1'b0, d);
  endtask

  task automatic dat(input logic [7:0] d);
    bus_cycle(1'b1, 1'b0, d);
  endtask

  task automatic read_cell(input int idx, output logic [7:0] v);
    @(negedge clk);
    rd_idx = idx[4:0];
    @(negedge clk);
    v = rd_char;
  endtask

  task automatic test_reset;
    logic [7:0] v;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      read_cell(i, v);
      n_cmp++; if (v !== 8'h20) begin n_bad++; $display("FAIL reset_cell[%0d] got %h want 20", i, v); end
    end
    n_cmp++; if (ddram_addr !== 7'h00) begin n_bad++; $display("FAIL reset_addr got %h want 00", ddram_addr); end
    n_cmp++; if ({inc_mode, disp_on, init_done, busy, drop_err, cmd_strobe} !== 6'b100000) begin
      n_bad++; $display("FAIL reset_flags got %b want 100000", {inc_mode, disp_on, init_done, busy, drop_err, cmd_strobe});
    end
  endtask

  task automatic test_init;
    int s0;
    s0 = strobe_cnt;
    cmd(8'h38); cmd(8'h0C); cmd(8'h06);
    n_cmp++; if ({init_done, disp_on, inc_mode} !== 3'b111) begin
      n_bad++; $display("FAIL init_flags got %b want 111", {init_done, disp_on, inc_mode});
    end
    n_cmp++; if (strobe_cnt - s0 !== 3) begin n_bad++; $display("FAIL init_strobes got %0d want 3", strobe_cnt - s0); end
  endtask

  task automatic test_two_line;
    logic [7:0] v;
    logic [7:0] seoul [5] = '{8'h53, 8'h45, 8'h4F, 8'h55, 8'h4C};
    logic [7:0] korea [5] = '{8'h4B, 8'h4F, 8'h52, 8'h45, 8'h41};
    cmd(8'h80);
    repeat (5) dat(8'h20);
    for (int i = 0; i < 5; i++) dat(seoul[i]);
    for (int i = 0; i < 5; i++) begin
      read_cell(5 + i, v);
      n_cmp++; if (v !== seoul[i]) begin n_bad++; $display("FAIL seoul_cell[%0d] got %h want %h", 5 + i, v, seoul[i]); end
    end
    n_cmp++; if (ddram_addr !== 7'h0A) begin n_bad++; $display("FAIL seoul_addr got %h want 0a", ddram_addr); end
    cmd(8'hC0);
    repeat (5) dat(8'h20);
    for (int i = 0; i < 5; i++) dat(korea[i]);
    for (int i = 0; i < 5; i++) begin
      read_cell(21 + i, v);
      n_cmp++; if (v !== korea[i]) begin n_bad++; $display("FAIL korea_cell[%0d] got %h want %h", 21 + i, v, korea[i]); end
    end
    n_cmp++; if (ddram_addr !== 7'h4A) begin n_bad++; $display("FAIL korea_addr got %h want 4a", ddram_addr); end
  endtask

  task automatic test_ignored;
    int s0;
    s0 = strobe_cnt;
    cmd(8'h10);
    n_cmp++; if (strobe_cnt - s0 !== 1) begin n_bad++; $display("FAIL shift_strobe got %0d want 1", strobe_cnt - s0); end
    s0 = strobe_cnt;
    cmd(8'h00);
    n_cmp++; if (strobe_cnt - s0 !== 0) begin n_bad++; $display("FAIL zero_strobe got %0d want 0", strobe_cnt - s0); end
    cmd(8'h48);
    n_cmp++; if (ddram_addr !== 7'h4A) begin n_bad++; $display("FAIL ignored_addr got %h want 4a", ddram_addr); end
  endtask

  task automatic test_wrap;
    logic [7:0] snap [32];
    logic [7:0] v;
    for (int i = 0; i < 32; i++) read_cell(i, snap[i]);
    cmd(8'hA7);
    dat(8'h58);
    n_cmp++; if (ddram_addr !== 7'h40) begin n_bad++; $display("FAIL wrap_inc_addr got %h want 40", ddram_addr); end
    for (int i = 0; i < 32; i++) begin
      read_cell(i, v);
      n_cmp++; if (v !== snap[i]) begin n_bad++; $display("FAIL wrap_nostore[%0d] got %h want %h", i, v, snap[i]); end
    end
    cmd(8'h04); cmd(8'h80);
    dat(8'h59);
    read_cell(0, v);
    n_cmp++; if (v !== 8'h59) begin n_bad++; $display("FAIL wrap_cell0 got %h want 59", v); end
    n_cmp++; if (ddram_addr !== 7'h67) begin n_bad++; $display("FAIL wrap_dec_addr got %h want 67", ddram_addr); end
    cmd(8'hC0);
    dat(8'h57);
    read_cell(16, v);
    n_cmp++; if (v !== 8'h57) begin n_bad++; $display("FAIL wrap_cell16 got %h want 57", v); end
    n_cmp++; if (ddram_addr !== 7'h27) begin n_bad++; $display("FAIL wrap_dec40_addr got %h want 27", ddram_addr); end
  endtask

  task automatic test_clear_collision;
    logic [7:0] v;
    int s0, b0, n;
    s0 = strobe_cnt;
    b0 = busy_cnt;
    cmd(8'h01);
    n = 0;
    while (!busy && n < 20) begin @(negedge clk); n++; end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL clear_busy_rise got %b want 1", busy); end
    repeat (2) @(negedge clk);
    dat(8'h5A);
    n = 0;
    while (busy && n < 100) begin @(negedge clk); n++; end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL clear_busy_fall got %b want 0", busy); end
    n_cmp++; if (busy_cnt - b0 !== 32) begin n_bad++; $display("FAIL clear_busy_len got %0d want 32", busy_cnt - b0); end
    n_cmp++; if (drop_err !== 1'b1) begin n_bad++; $display("FAIL clear_drop_err got %b want 1", drop_err); end
    n_cmp++; if (strobe_cnt - s0 !== 1) begin n_bad++; $display("FAIL clear_strobes got %0d want 1", strobe_cnt - s0); end
    n_cmp++; if ({ddram_addr, inc_mode} !== {7'h00, 1'b1}) begin
      n_bad++; $display("FAIL clear_addr_inc got %h/%b want 00/1", ddram_addr, inc_mode);
    end
    for (int i = 0; i < 32; i++) begin
      read_cell(i, v);
      n_cmp++; if (v !== 8'h20) begin n_bad++; $display("FAIL clear_cell[%0d] got %h want 20", i, v); end
    end
  endtask

  task automatic test_reset_mid_clear;
    logic [7:0] v;
    int s0, n;
    cmd(8'hC0);
    dat(8'h51);
    read_cell(16, v);
    n_cmp++; if (v !== 8'h51) begin n_bad++; $display("FAIL pre_clear_cell16 got %h want 51", v); end
    cmd(8'h01);
    n = 0;
    while (!busy && n < 20) begin @(negedge clk); n++; end
    repeat (12) @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++; if ({busy, drop_err, init_done, disp_on, inc_mode, cmd_strobe} !== 6'b000010) begin
      n_bad++; $display("FAIL midclr_flags got %b want 000010", {busy, drop_err, init_done, disp_on, inc_mode, cmd_strobe});
    end
    n_cmp++; if ({ddram_addr, rd_char} !== {7'h00, 8'h20}) begin
      n_bad++; $display("FAIL midclr_addr_rd got %h/%h want 00/20", ddram_addr, rd_char);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      read_cell(i, v);
      n_cmp++; if (v !== 8'h20) begin n_bad++; $display("FAIL midclr_cell[%0d] got %h want 20", i, v); end
    end
    s0 = strobe_cnt;
    bus_cycle(1'b1, 1'b1, 8'h52);
    bus_cycle(1'b0, 1'b1, 8'h01);
    bus_cycle(1'b0, 1'b1, 8'h0C);
    n_cmp++; if (strobe_cnt - s0 !== 0) begin n_bad++; $display("FAIL read_strobes got %0d want 0", strobe_cnt - s0); end
    n_cmp++; if ({busy, disp_on, ddram_addr} !== {1'b0, 1'b0, 7'h00}) begin
      n_bad++; $display("FAIL read_state got %b/%b/%h want 0/0/00", busy, disp_on, ddram_addr);
    end
    read_cell(0, v);
    n_cmp++; if (v !== 8'h20) begin n_bad++; $display("FAIL read_cell0 got %h want 20", v); end
  endtask

  initial begin
    test_reset;
    test_init;
    test_two_line;
    test_ignored;
    test_wrap;
    test_clear_collision;
    test_reset_mid_clear;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
